// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with registered read data, registered
// full/empty flags and overflow/underflow reporting.
// Optional build macro ASYNC_FIFO_STICKY_ERR_EN: when defined, the
// overflow/underflow flags latch on the first error until reset; otherwise
// they pulse for one cycle per rejected request.
module async_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_SIZE  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  data_valid,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  // Index width into storage; the pointer carries one extra wrap bit.
  localparam int IDX_W = ADDR_SIZE - 1;

  logic [ADDR_SIZE-1:0]  wr_ptr;
  logic [ADDR_SIZE-1:0]  rd_ptr;
  logic [ADDR_SIZE-1:0]  wr_ptr_nxt;
  logic [ADDR_SIZE-1:0]  rd_ptr_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_rej;
  logic                  rd_rej;
  logic                  empty_nxt;
  logic                  full_nxt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Accept/reject decisions use the registered flags; next pointers and flags follow from them.
  always_comb begin
    wr_acc     = write_enable & ~fifo_full;
    rd_acc     = read_enable & ~fifo_empty;
    wr_rej     = write_enable & fifo_full;
    rd_rej     = read_enable & fifo_empty;
    wr_ptr_nxt = wr_ptr + {{IDX_W{1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{IDX_W{1'b0}}, rd_acc};
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[ADDR_SIZE-1] != rd_ptr_nxt[ADDR_SIZE-1]) &&
                 (wr_ptr_nxt[IDX_W-1:0] == rd_ptr_nxt[IDX_W-1:0]);
  end

  // Pointers, status flags and error flags; all cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_empty     <= 1'b1;
      fifo_full      <= 1'b0;
      data_valid     <= 1'b0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fifo_empty <= empty_nxt;
      fifo_full  <= full_nxt;
      data_valid <= rd_acc;
`ifdef ASYNC_FIFO_STICKY_ERR_EN
      fifo_overflow  <= fifo_overflow | wr_rej;
      fifo_underflow <= fifo_underflow | rd_rej;
`else
      fifo_overflow  <= wr_rej;
      fifo_underflow <= rd_rej;
`endif
    end
  end

  // Read data register: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr[IDX_W-1:0]];
    end
  end

  // Storage array is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[IDX_W-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed and randomized bench for async_fifo, checked
// against a queue-based occupancy model.
module tb_async_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          write_enable = 1'b0;
  logic          read_enable = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          fifo_full;
  logic          fifo_empty;
  logic          data_valid;
  logic          fifo_overflow;
  logic          fifo_underflow;

  async_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_SIZE(6)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_enable  (write_enable),
    .read_enable   (read_enable),
    .data_in       (data_in),
    .data_out      (data_out),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .data_valid    (data_valid),
    .fifo_overflow (fifo_overflow),
    .fifo_underflow(fifo_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_udf;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"},  32'(data_out),       32'(exp_dout));
    check({tag, ".valid"},     32'(data_valid),     32'(exp_valid));
    check({tag, ".empty"},     32'(fifo_empty),     32'(q.size() == 0));
    check({tag, ".full"},      32'(fifo_full),      32'(q.size() == DEPTH));
    check({tag, ".overflow"},  32'(fifo_overflow),  32'(exp_ovf));
    check({tag, ".underflow"}, 32'(fifo_underflow), 32'(exp_udf));
  endtask

  // One clock cycle of stimulus, model update, and output check.
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din, input string tag);
    bit wr_ok, rd_ok;
    int occ;
    @(negedge clk);
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    @(posedge clk);
    #1;
    occ   = q.size();
    rd_ok = re && (occ > 0);
    wr_ok = we && (occ < DEPTH);
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    exp_valid = rd_ok;
`ifdef ASYNC_FIFO_STICKY_ERR_EN
    exp_ovf = exp_ovf | (we && !wr_ok);
    exp_udf = exp_udf | (re && !rd_ok);
`else
    exp_ovf = we && !wr_ok;
    exp_udf = re && !rd_ok;
`endif
    check_all(tag);
  endtask

  // Assert reset away from the clock edge, check it takes effect at once, then release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    check_all(tag);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] wval;
    logic [DW-1:0] d_aaaa;
    d_aaaa = 16'hAAAA;

    // Power-on reset
    do_reset("por");

    // Single write then read
    cycle(1'b1, 1'b0, d_aaaa, "wr_aaaa");
    cycle(1'b0, 1'b1, '0, "rd_aaaa");
    check("rd_aaaa.value", 32'(data_out), 32'h0000AAAA);
    cycle(1'b0, 1'b0, '0, "idle_after_rd");

    // Read while empty
    cycle(1'b0, 1'b1, '0, "rd_empty");
    check("rd_empty.hold", 32'(data_out), 32'h0000AAAA);
    cycle(1'b0, 1'b0, '0, "udf_clear");

    // Alternate patterns
    cycle(1'b1, 1'b0, 16'h5555, "wr_5555");
    cycle(1'b0, 1'b1, '0, "rd_5555");
    check("rd_5555.value", 32'(data_out), 32'h00005555);
    cycle(1'b1, 1'b0, 16'hFFFF, "wr_ffff");
    cycle(1'b0, 1'b1, '0, "rd_ffff");
    check("rd_ffff.value", 32'(data_out), 32'h0000FFFF);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), "fill");
    check("fill.full", 32'(fifo_full), 32'd1);
    cycle(1'b1, 1'b0, 16'hBEEF, "wr_overflow");
    check("wr_overflow.flag", 32'(fifo_overflow), 32'd1);
    cycle(1'b1, 1'b1, 16'hCAFE, "rw_full");
    cycle(1'b0, 1'b0, '0, "ovf_clear");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, "drain");
    check("drain.empty", 32'(fifo_empty), 32'd1);
    cycle(1'b1, 1'b1, 16'h1234, "rw_empty");
    cycle(1'b0, 1'b1, '0, "rd_after_rw_empty");

    // Streaming at constant occupancy 5 across pointer wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'($urandom), "pre5");
    for (int i = 0; i < 100; i++) begin
      wval = DW'($urandom);
      cycle(1'b1, 1'b1, wval, "stream");
    end
    check("stream.occ", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, "post5");

    // Random traffic, biased to visit both full and empty
    for (int i = 0; i < 400; i++) begin
      logic we, re;
      if ((i / 100) % 2 == 0) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      cycle(we, re, DW'($urandom), "random");
    end

    // Reset mid-operation at occupancy 10
    do_reset("pre_r40");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(16'h0100 + i), "occ10");
    @(negedge clk);
    write_enable = 1'b1;
    read_enable  = 1'b1;
    data_in      = 16'h7777;
    do_reset("mid_reset");
    cycle(1'b0, 1'b1, '0, "rd_after_reset");
    check("rd_after_reset.udf", 32'(fifo_underflow), 32'd1);
    cycle(1'b1, 1'b0, 16'h4242, "wr_after_reset");
    cycle(1'b0, 1'b1, '0, "rd_4242");
    check("rd_4242.value", 32'(data_out), 32'h00004242);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
